aes_sched: RTL and testbench

// Two-requester scheduler that shares one AES core between independent clients.

---
 rtl/aes_sched_pkg.sv | 10 +
 rtl/aes_sched_rr_arb2.sv | 15 +
 rtl/aes_sched.sv | 112 +++++++++++
 tb/tb_aes_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared state encoding, key-width check and FIPS-197 reference vectors
package aes_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, RESP} state_t;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  function automatic bit k_legal(input int k);
    return k == 128 || k == 192 || k == 256;
  endfunction
endpackage

// File: rtl/aes_sched_rr_arb2.sv
// aes_sched_rr_arb2: two-input round-robin arbiter, one-hot grant, pointer moves past the winner
module aes_sched_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);
  logic ptr;
  assign gnt[0] = req[0] & (!ptr | !req[1]);
  assign gnt[1] = req[1] & (ptr | !req[0]);
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= 1'b0;
    else if (upd && |req) ptr <= gnt[0];
endmodule

// File: rtl/aes_sched.sv
// aes_sched: shares one AES core between two requesters, drives the load pulse and returns tagged results
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int K           = 128,
  parameter int LOAD_CYCLES = 32,
  parameter int TIMEOUT     = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_dir,
  input  logic [K-1:0]   req0_key,
  input  logic [127:0]   req0_msg,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_dir,
  input  logic [K-1:0]   req1_key,
  input  logic [127:0]   req1_msg,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic           resp_err,
  output logic [127:0]   resp_data,
  output logic           core_ce,
  output logic           core_dir,
  output logic [K-1:0]   core_key,
  output logic [127:0]   core_msg,
  input  logic           core_done,
  input  logic [127:0]   core_data
);
  localparam int MX = (LOAD_CYCLES > TIMEOUT) ? LOAD_CYCLES : TIMEOUT;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] LOAD_END = CW'(LOAD_CYCLES - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT - 1);
  if (!k_legal(K)) begin : g_k_illegal
    $error("aes_sched: K must be 128, 192 or 256");
  end
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    done_q;
  logic [1:0]    gnt;
  logic          done_s;
  assign done_s = done_q[1];
  aes_sched_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .upd   (state == IDLE),
    .gnt   (gnt)
  );
  // core_done comes from the core's own clock domain
  always_ff @(posedge clk or negedge reset)
    if (!reset) done_q <= 2'b00;
    else done_q <= {done_q[0], core_done};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      core_ce    <= 1'b0;
      core_dir   <= 1'b0;
      core_key   <= '0;
      core_msg   <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        IDLE: if (|gnt) begin
          req0_ready <= gnt[0];
          req1_ready <= gnt[1];
          core_dir   <= gnt[1] ? req1_dir : req0_dir;
          core_key   <= gnt[1] ? req1_key : req0_key;
          core_msg   <= gnt[1] ? req1_msg : req0_msg;
          resp_id    <= gnt[1];
          core_ce    <= 1'b1;
          cnt        <= '0;
          state      <= LOAD;
        end
        LOAD: if (cnt == LOAD_END) begin
          core_ce <= 1'b0;
          cnt     <= '0;
          state   <= ARM;
        end else cnt <= cnt + CW'(1);
        ARM, RUN: if (state == RUN && done_s) begin
          resp_data  <= core_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end else if (cnt == TO_END) begin
          resp_data  <= '0;
          resp_err   <= 1'b1;
          resp_valid <= 1'b1;
          state      <= RESP;
        end else begin
          cnt <= cnt + CW'(1);
          if (state == ARM && !done_s) state <= RUN;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_sched.sv
// tb_aes_sched: drives aes_sched against a behavioural core model and checks responses
module tb_aes_sched;
  import aes_sched_pkg::*;
  localparam int K = 128, L = 8, T = 64;
  logic clk = 1'b0, reset = 1'b0;
  logic req0_valid = 1'b0, req0_dir = 1'b0, req1_valid = 1'b0, req1_dir = 1'b0, resp_ready = 1'b1;
  logic [K-1:0] req0_key = '0, req1_key = '0;
  logic [127:0] req0_msg = '0, req1_msg = '0;
  logic req0_ready, req1_ready, resp_valid, resp_id, resp_err, core_ce, core_dir;
  logic [127:0] resp_data, core_msg;
  logic [K-1:0] core_key;
  logic core_done = 1'b0;
  logic [127:0] core_data = '0;
  always #5 clk = ~clk;
  aes_sched #(.K(K), .LOAD_CYCLES(L), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dir(req0_dir), .req0_key(req0_key), .req0_msg(req0_msg),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dir(req1_dir), .req1_key(req1_key), .req1_msg(req1_msg),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_err(resp_err), .resp_data(resp_data),
    .core_ce(core_ce), .core_dir(core_dir), .core_key(core_key), .core_msg(core_msg),
    .core_done(core_done), .core_data(core_data)
  );
  int tests = 0, fails = 0;
  int delay = 3, ce_cnt = 0;
  bit never = 1'b0, fav = 1'b0;
  // Stand-in for the AES core: FIPS-197 vectors are exact, anything else uses a fixed scramble
  function automatic logic [127:0] ref_core(input bit dir, input logic [127:0] key, input logic [127:0] msg);
    if (!dir && key == FIPS_KEY && msg == FIPS_PT) return FIPS_CT;
    if (dir && key == FIPS_KEY && msg == FIPS_CT) return FIPS_PT;
    return {msg[63:0], msg[127:64]} ^ key ^ {128{dir}};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin : core_model
    logic ce_prev, armed, pending, m_dir;
    logic [127:0] m_key, m_msg;
    int wcnt;
    ce_prev = 1'b0; armed = 1'b0; pending = 1'b0; wcnt = 0;
    m_dir = 1'b0; m_key = '0; m_msg = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        core_done = 1'b0; armed = 1'b0; pending = 1'b0;
      end else if (core_ce && !ce_prev) begin
        core_done = 1'b0; core_data = rnd128();
        m_dir = core_dir; m_key = core_key; m_msg = core_msg; armed = 1'b1;
      end else if (!core_ce && ce_prev && armed) begin
        armed = 1'b0; pending = !never; wcnt = delay;
      end else if (pending) begin
        if (wcnt == 0) begin
          core_data = ref_core(m_dir, m_key, m_msg); core_done = 1'b1; pending = 1'b0;
        end else wcnt--;
      end
      if (core_ce) ce_cnt++;
      ce_prev = core_ce;
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic send(input bit id, input bit dir, input logic [127:0] key, input logic [127:0] msg);
    int n = 0;
    if (id) begin req1_dir = dir; req1_key = key; req1_msg = msg; req1_valid = 1'b1; end
    else begin req0_dir = dir; req0_key = key; req0_msg = msg; req0_valid = 1'b1; end
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) chk("grant_wait", 128'(n), 128'(0));
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    fav = !id;
  endtask
  task automatic wait_resp(output int c);
    c = 0;
    while (!resp_valid && c < L + T + 200) begin c++; @(negedge clk); end
    if (!resp_valid) chk("resp_wait", 128'(c), 128'(0));
  endtask
  task automatic expect_resp(input string nm, input bit id, input bit err, input logic [127:0] data, output int c);
    wait_resp(c);
    chk({nm, "_id"}, 128'(resp_id), 128'(id));
    chk({nm, "_err"}, 128'(resp_err), 128'(err));
    chk({nm, "_data"}, resp_data, data);
    @(negedge clk);
  endtask
  typedef struct {bit id; bit dir; logic [127:0] key; logic [127:0] msg; logic [127:0] exp;} vec_t;
  initial begin
    vec_t vt[4];
    int c, bad;
    logic [127:0] k, m, e, snap;
    bit d, id, f0;
    vt[0] = '{1'b0, 1'b0, FIPS_KEY, FIPS_PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[1] = '{1'b1, 1'b1, FIPS_KEY, FIPS_CT, 128'h00112233445566778899aabbccddeeff};
    vt[2] = '{1'b0, 1'b1, 128'h1, 128'hffff0000, 128'h0};
    vt[3] = '{1'b1, 1'b0, 128'hcafe, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'h0};
    for (int i = 2; i < 4; i++) vt[i].exp = ref_core(vt[i].dir, vt[i].key, vt[i].msg);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 128'({resp_valid, resp_err, resp_id, core_ce, core_dir, req0_ready, req1_ready}), 128'(0));
    chk("rst_data", resp_data | core_msg | core_key, 128'(0));
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send(vt[i].id, vt[i].dir, vt[i].key, vt[i].msg);
      expect_resp($sformatf("vec%0d", i), vt[i].id, 1'b0, vt[i].exp, c);
    end
    for (int i = 0; i < 10; i++) begin
      id = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
      k = rnd128(); m = rnd128(); delay = $urandom_range(0, 30);
      send(id, d, k, m);
      expect_resp($sformatf("rand%0d", i), id, 1'b0, ref_core(d, k, m), c);
    end
    begin : contention
      logic [127:0] q0[$], q1[$];
      bit gq[$];
      f0 = fav; delay = 2;
      fork
        for (int j = 0; j < 3; j++) begin
          int n = 0;
          req0_dir = 1'($urandom_range(0, 1)); req0_key = rnd128(); req0_msg = rnd128();
          q0.push_back(ref_core(req0_dir, req0_key, req0_msg)); req0_valid = 1'b1;
          @(negedge clk);
          while (!req0_ready && n < 400) begin n++; @(negedge clk); end
          if (req0_ready) gq.push_back(1'b0);
          if (j == 2) req0_valid = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
          int n = 0;
          req1_dir = 1'($urandom_range(0, 1)); req1_key = rnd128(); req1_msg = rnd128();
          q1.push_back(ref_core(req1_dir, req1_key, req1_msg)); req1_valid = 1'b1;
          @(negedge clk);
          while (!req1_ready && n < 400) begin n++; @(negedge clk); end
          if (req1_ready) gq.push_back(1'b1);
          if (j == 2) req1_valid = 1'b0;
        end
        for (int j = 0; j < 6; j++) begin
          bit eid;
          logic [127:0] ed;
          eid = f0 ^ 1'(j);
          ed = eid ? (q1.size() > 0 ? q1.pop_front() : 'x) : (q0.size() > 0 ? q0.pop_front() : 'x);
          expect_resp($sformatf("cont%0d", j), eid, 1'b0, ed, c);
        end
      join
      chk("cont_grants", 128'(gq.size()), 128'(6));
      for (int j = 0; j < gq.size() && j < 6; j++)
        chk($sformatf("cont_grant%0d", j), 128'(gq[j]), 128'(f0 ^ 1'(j)));
      fav = f0;
    end
    resp_ready = 1'b0;
    k = rnd128(); m = rnd128();
    send(1'b0, 1'b0, k, m);
    req1_dir = 1'b1; req1_key = rnd128(); req1_msg = rnd128(); req1_valid = 1'b1;
    e = ref_core(1'b1, req1_key, req1_msg);
    wait_resp(c);
    snap = resp_data; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== snap || resp_id !== 1'b0 || req0_ready || req1_ready) bad++;
    end
    chk("bp_hold", 128'(bad), 128'(0));
    chk("bp_data", resp_data, ref_core(1'b0, k, m));
    resp_ready = 1'b1;
    c = 0;
    @(negedge clk);
    while (!req1_ready && c < 20) begin c++; @(negedge clk); end
    chk("bp_grant_after_accept", 128'(req1_ready), 128'(1));
    req1_valid = 1'b0; fav = 1'b0;
    expect_resp("bp_next", 1'b1, 1'b0, e, c);
    never = 1'b1; ce_cnt = 0;
    send(1'b1, 1'b0, FIPS_KEY, FIPS_PT);
    expect_resp("timeout", 1'b1, 1'b1, 128'(0), c);
    chk("timeout_latency", 128'(c), 128'(L + T));
    chk("ce_width", 128'(ce_cnt), 128'(L));
    never = 1'b0;
    send(1'b0, 1'b0, FIPS_KEY, FIPS_PT);
    expect_resp("after_timeout", 1'b0, 1'b0, FIPS_CT, c);
    delay = 40;
    send(1'b1, 1'b1, FIPS_KEY, FIPS_CT);
    repeat (L + 20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", 128'({resp_valid, resp_err, resp_id, core_ce, core_dir, req0_ready, req1_ready}), 128'(0));
    chk("midrst_data", resp_data | core_msg | core_key, 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1; fav = 1'b0; delay = 3; bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || core_ce !== 1'b0) bad++;
    end
    chk("midrst_no_resp", 128'(bad), 128'(0));
    send(1'b1, 1'b1, FIPS_KEY, FIPS_CT);
    expect_resp("after_rst", 1'b1, 1'b0, FIPS_PT, c);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
